fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers up to two returning instructions. It drives the IF/ID pipeline register that feeds decode and the hazard detection controller. It honours the hazard controller's stall and the execute stage's branch/jump redirect, discarding wrong-path fetches.

## Interface
- RESET_PC, 32'h8002_0000, first fetch address after reset
- DEPTH, 2, max outstanding plus buffered fetches (credit limit)

Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- w_stall  in  1  hold IF/ID and stop draining the buffer (hazard controller)
- w_redirect  in  1  taken branch/jump resolved in execute
- w_redirect_pc_32  in  32  redirect target; bits [1:0] forced to 0
- w_imem_req_valid  out  1  fetch request valid
- w_imem_req_addr_32  out  32  fetch address (= PC)
- w_imem_req_ready  in  1  memory accepts request
- w_imem_rsp_valid  in  1  instruction word returning, in request order, ≥1 cycle after accept
- w_imem_rsp_data_32  in  32  instruction word
- w_fd_valid  out  1  IF/ID holds a real instruction
- w_fd_nop  out  1  IF/ID holds a bubble (= ~w_fd_valid)
- w_fd_pc_32  out  32  PC of IF/ID instruction
- w_fd_insn_32  out  32  IF/ID instruction; 0 when bubble

## Operation
- State: pc, inflight PC queue (DEPTH entries, count 0..DEPTH), response buffer {pc, insn} (DEPTH entries, count 0..DEPTH), drop counter (0..DEPTH), IF/ID register.
- Credit = DEPTH − inflight − buffered, from registered counts only (conservative; a same-cycle response does not free credit).
- w_imem_req_valid = ~reset & ~w_redirect & (credit > 0); w_imem_req_addr_32 = pc.
- Accept (req_valid & req_ready): push pc into inflight queue; pc <= pc + 4 (32-bit wrap 32'hFFFF_FFFC -> 0).
- Response while drop counter > 0: discard; drop counter −1; inflight −1.
- Response otherwise: pop inflight PC and pair it with the data. The pair goes straight into IF/ID if the buffer is empty and IF/ID is loading this cycle. Otherwise it is pushed into the buffer.
- Response with inflight = 0: ignored (protocol violation).
- IF/ID load (w_stall = 0, no redirect):
  - buffer non-empty: load head, pop; valid = 1.
  - else a bypassable response is present: load it; valid = 1.
  - else bubble: valid = 0, pc = 0, insn = 0.
- w_stall = 1: IF/ID and buffer head hold. Fetch continues until credit reaches 0.
- Redirect (priority over stall and everything else):
  - pc <= redirect target.
  - Buffer cleared.
  - IF/ID <= bubble.
  - Drop counter <= inflight − (response this cycle ? 1 : 0); the same-cycle response is itself discarded.
  - No request issued this cycle.
- Redirect while drops are pending: the drop counter is recomputed as above; no fetch from either old path is ever delivered.

## Timing
- Reset values: pc = RESET_PC; all counts 0; w_imem_req_valid = 0; w_fd_valid = 0; w_fd_nop = 1; w_fd_pc_32 = 0; w_fd_insn_32 = 0.
- First request (addr RESET_PC) is in the first cycle with reset low.
- Response in cycle N with buffer empty and no stall -> w_fd_valid = 1 in cycle N+1.
- Request-to-IF/ID latency = memory latency + 1 cycle.
- Throughput with 1-cycle memory and ready = 1: one instruction per cycle, no bubbles after the first.
- Redirect asserted in cycle N:
  - IF/ID is a bubble in N+1.
  - First target request in N+1.
  - With 1-cycle memory, the target instruction is valid in IF/ID at N+3.
- Reset mid-operation clears everything in one cycle. Responses arriving after reset for pre-reset requests are ignored (inflight = 0).

## Test plan
- Reset release, memory ready = 1, 1-cycle latency, words = addr ^ 32'hA5A5_A5A5 -> fd_pc = 8002_0000, 8002_0004, 8002_0008… on consecutive cycles starting two cycles after reset low.
- Stall high for 3 cycles mid-stream -> IF/ID holds the same pc/insn for the stall cycles. req_valid falls once inflight + buffered = 2. No instruction is lost or duplicated after release.
- Redirect to 32'h8002_0103 with 2 fetches in flight -> both wrong-path responses dropped, next fd_pc = 8002_0100, and no IF/ID valid between.
- Redirect and stall asserted in the same cycle -> IF/ID becomes bubble (fd_nop = 1) next cycle; redirect wins.
- req_ready low 4 cycles, then a random 1–3 cycle response latency -> in-order delivery, pc strictly +4 per valid, at most 2 outstanding at any time.
- Reset pulsed with 2 fetches in flight; late responses arrive after reset -> ignored; first fd_pc after reset = 8002_0000.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the
//             PC, issues in-order fetch requests over a valid/ready handshake,
//             buffers returning instructions and drives the IF/ID register.
//             Redirects from execute discard all wrong-path fetches.
//  Ports    : clock, reset              - clock, synchronous active-high reset
//             w_stall                   - hold IF/ID and the buffer head
//             w_redirect, w_redirect_pc_32 - taken branch/jump and its target
//             w_imem_req_*              - fetch request (valid/ready/addr)
//             w_imem_rsp_*              - in-order instruction responses
//             w_fd_*                    - IF/ID register towards decode
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_stall,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc_32,
    output logic        w_imem_req_valid,
    output logic [31:0] w_imem_req_addr_32,
    input  logic        w_imem_req_ready,
    input  logic        w_imem_rsp_valid,
    input  logic [31:0] w_imem_rsp_data_32,
    output logic        w_fd_valid,
    output logic        w_fd_nop,
    output logic [31:0] w_fd_pc_32,
    output logic [31:0] w_fd_insn_32
);

    localparam int               c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_pc;
    logic [31:0]        r_inf_pc   [DEPTH];   // PCs of requests awaiting data
    logic [c_CNT_W-1:0] r_inf_cnt;
    logic [31:0]        r_buf_pc   [DEPTH];   // returned but not yet in IF/ID
    logic [31:0]        r_buf_insn [DEPTH];
    logic [c_CNT_W-1:0] r_buf_cnt;
    logic [c_CNT_W-1:0] r_drop_cnt;           // wrong-path responses still due
    logic               r_fd_valid;
    logic [31:0]        r_fd_pc;
    logic [31:0]        r_fd_insn;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_CNT_W:0]   w_used;
    logic               w_req_valid;
    logic               w_accept;
    logic               w_rsp_live;
    logic               w_rsp_keep;
    logic               w_load;
    logic               w_buf_empty;
    logic               w_bypass;
    logic               w_buf_pop;
    logic               w_buf_push;
    logic [c_CNT_W-1:0] w_inf_base;
    logic [c_CNT_W-1:0] w_buf_base;

    // Credit uses registered counts only: a response arriving this cycle
    // does not free a slot until the next cycle.
    assign w_used      = {1'b0, r_inf_cnt} + {1'b0, r_buf_cnt};
    assign w_req_valid = ~reset & ~w_redirect & (w_used < c_DEPTH);
    assign w_accept    = w_req_valid & w_imem_req_ready;

    // A response with nothing in flight is a protocol violation; ignore it.
    assign w_rsp_live  = w_imem_rsp_valid & (r_inf_cnt != '0);
    // A response coinciding with a redirect belongs to the old path.
    assign w_rsp_keep  = w_rsp_live & (r_drop_cnt == '0) & ~w_redirect;

    assign w_load      = ~w_stall & ~w_redirect;
    assign w_buf_empty = (r_buf_cnt == '0);
    // Skip the buffer only when it is empty, otherwise ordering would break.
    assign w_bypass    = w_rsp_keep & w_buf_empty & w_load;
    assign w_buf_pop   = w_load & ~w_buf_empty;
    assign w_buf_push  = w_rsp_keep & ~w_bypass;

    // Occupancy after this cycle's pop; also the slot index for a push.
    assign w_inf_base  = r_inf_cnt - c_CNT_W'(w_rsp_live);
    assign w_buf_base  = r_buf_cnt - c_CNT_W'(w_buf_pop);

    // ------------------------------------------------------------------
    // Control registers and IF/ID
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inf_cnt  <= '0;
            r_buf_cnt  <= '0;
            r_drop_cnt <= '0;
            r_fd_valid <= 1'b0;
            r_fd_pc    <= '0;
            r_fd_insn  <= '0;
        end else begin
            r_inf_cnt <= w_inf_base + c_CNT_W'(w_accept);
            if (w_redirect) begin
                r_pc       <= w_redirect_pc_32 & 32'hFFFF_FFFC;
                r_buf_cnt  <= '0;
                // Everything still in flight after this cycle is wrong-path.
                r_drop_cnt <= w_inf_base;
                r_fd_valid <= 1'b0;
                r_fd_pc    <= '0;
                r_fd_insn  <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                r_buf_cnt <= w_buf_base + c_CNT_W'(w_buf_push);
                if (w_rsp_live && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                end
                if (w_load) begin
                    if (!w_buf_empty) begin
                        r_fd_valid <= 1'b1;
                        r_fd_pc    <= r_buf_pc[0];
                        r_fd_insn  <= r_buf_insn[0];
                    end else if (w_bypass) begin
                        r_fd_valid <= 1'b1;
                        r_fd_pc    <= r_inf_pc[0];
                        r_fd_insn  <= w_imem_rsp_data_32;
                    end else begin
                        r_fd_valid <= 1'b0;
                        r_fd_pc    <= '0;
                        r_fd_insn  <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (shift-down FIFOs; counts above give validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_rsp_live) begin
                r_inf_pc[i] <= r_inf_pc[i+1];
            end
            if (w_buf_pop) begin
                r_buf_pc[i]   <= r_buf_pc[i+1];
                r_buf_insn[i] <= r_buf_insn[i+1];
            end
        end
        // Pushes come after the shift so a same-cycle push wins its slot.
        for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && (w_inf_base == c_CNT_W'(i))) begin
                r_inf_pc[i] <= r_pc;
            end
            if (w_buf_push && (w_buf_base == c_CNT_W'(i))) begin
                r_buf_pc[i]   <= r_inf_pc[0];
                r_buf_insn[i] <= w_imem_rsp_data_32;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_imem_req_valid   = w_req_valid;
    assign w_imem_req_addr_32 = r_pc;
    assign w_fd_valid         = r_fd_valid;
    assign w_fd_nop           = ~r_fd_valid;
    assign w_fd_pc_32         = r_fd_pc;
    assign w_fd_insn_32       = r_fd_insn;

endmodule
`default_nettype wire
